// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_M = 4;
  localparam int CNT_W = $clog2(DEF_N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider_seq_restoring_if.sv
// Request/response bundle of the restoring divider.
// The div_err signal exists only when DIV_ZERO_ERR_EN is defined.
interface divider_seq_restoring_if #(
  parameter int N = 8,
  parameter int M = 4
);

  logic         start;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         ready;
  logic         done;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
`ifdef DIV_ZERO_ERR_EN
  logic         div_err;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_err
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_err
  );
`else
  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder
  );
`endif

endinterface

// File: rtl/div_step.sv
// One combinational restoring step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int M = 4
) (
  input  logic [M-1:0] r,
  input  logic         bit_in,
  input  logic [M-1:0] v,
  output logic [M-1:0] r_out,
  output logic         q_bit
);

  logic [M:0] t;

  // The partial remainder is always below the divisor, so it fits back into M bits.
  always_comb begin
    t     = {r, bit_in};
    q_bit = (t >= {1'b0, v});
    r_out = q_bit ? M'(t - {1'b0, v}) : t[M-1:0];
  end

endmodule

// File: rtl/divider_seq_restoring.sv
// Sequential restoring divider, one quotient bit per clock (IDLE -> RUN -> DONE).
// Optional DIV_ZERO_ERR_EN: divide-by-zero shortcut straight to DONE with div_err.
module divider_seq_restoring
  import div_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic                    clk,
  input  logic                    rst_n,
  divider_seq_restoring_if.slave  bus
);

  localparam int CW = $clog2(N + 1);

  state_t         state, state_next;
  logic [N-1:0]   dq_reg;
  logic [M-1:0]   v_reg;
  logic [M-1:0]   r_reg;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   quotient_reg;
  logic [M-1:0]   remainder_reg;
  logic [M-1:0]   r_step;
  logic           q_bit;
  logic           ready;
  logic           done;
  logic           zero_div;
`ifdef DIV_ZERO_ERR_EN
  logic           div_err_reg;
`endif

  // Dividend bits leave dq_reg at the top while quotient bits enter at the bottom.
  div_step #(.M(M)) u_step (
    .r      (r_reg),
    .bit_in (dq_reg[N-1]),
    .v      (v_reg),
    .r_out  (r_step),
    .q_bit  (q_bit)
  );

`ifdef DIV_ZERO_ERR_EN
  assign zero_div = (bus.divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.start) state_next = zero_div ? DONE : RUN;
      end
      RUN: begin
        if (cnt == CW'(1)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Results land on the final RUN edge so they are already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_reg        <= '0;
      v_reg         <= '0;
      r_reg         <= '0;
      cnt           <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
`ifdef DIV_ZERO_ERR_EN
      div_err_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dq_reg <= bus.dividend;
            v_reg  <= bus.divisor;
            r_reg  <= '0;
            cnt    <= CW'(N);
`ifdef DIV_ZERO_ERR_EN
            div_err_reg <= 1'b0;
            if (zero_div) begin
              quotient_reg  <= '1;
              remainder_reg <= bus.dividend[M-1:0];
              div_err_reg   <= 1'b1;
            end
`endif
          end
        end
        RUN: begin
          dq_reg <= {dq_reg[N-2:0], q_bit};
          r_reg  <= r_step;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            quotient_reg  <= {dq_reg[N-2:0], q_bit};
            remainder_reg <= r_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = ready;
  assign bus.done      = done;
  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
`ifdef DIV_ZERO_ERR_EN
  assign bus.div_err   = div_err_reg;
`endif

endmodule

// File: tb/tb_divider_seq_restoring.sv
// Directed self-checking bench for divider_seq_restoring (honours DIV_ZERO_ERR_EN).
`timescale 1ns/1ps
module tb_divider_seq_restoring;

  localparam int N = 8;
  localparam int M = 4;
`ifdef DIV_ZERO_ERR_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = N + 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   compared = 0;
  int   mismatched = 0;

  divider_seq_restoring_if #(.N(N), .M(M)) bus ();

  divider_seq_restoring #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One operation: start for a single cycle, scramble inputs, then time and check the result.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [M-1:0] b,
                               input int exp_q, input int exp_r, input int exp_lat,
                               input string tag);
    int lat;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = N'($urandom);
    bus.divisor  = M'($urandom);
    checkOutput({tag, " ready_low"}, 32'(bus.ready), 0);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, " latency"}, lat, exp_lat);
    checkOutput({tag, " quotient"}, 32'(bus.quotient), exp_q);
    checkOutput({tag, " remainder"}, 32'(bus.remainder), exp_r);
    @(posedge clk); #1;
    checkOutput({tag, " done_pulse"}, 32'(bus.done), 0);
    checkOutput({tag, " ready_back"}, 32'(bus.ready), 1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int dones;
    int lat;
    logic [31:0] q_seen;
    logic [31:0] r_seen;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;

    repeat (2) @(posedge clk); #1;
    checkOutput("rst ready", 32'(bus.ready), 1);
    checkOutput("rst done", 32'(bus.done), 0);
    checkOutput("rst quotient", 32'(bus.quotient), 0);
    checkOutput("rst remainder", 32'(bus.remainder), 0);
`ifdef DIV_ZERO_ERR_EN
    checkOutput("rst div_err", 32'(bus.div_err), 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle ready", 32'(bus.ready), 1);
    checkOutput("idle done", 32'(bus.done), 0);

    applyStimulus(8'd225, 4'd15, 15, 0, 9, "225/15");
    repeat (3) @(posedge clk); #1;
    checkOutput("hold quotient", 32'(bus.quotient), 15);
    checkOutput("hold remainder", 32'(bus.remainder), 0);
    checkOutput("hold done", 32'(bus.done), 0);

    applyStimulus(8'd100, 4'd7, 14, 2, 9, "100/7");
    applyStimulus(8'd3, 4'd5, 0, 3, 9, "3/5");
    applyStimulus(8'd255, 4'd1, 255, 0, 9, "255/1");

    // A second start during RUN must not disturb the running 100/7.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 4'd7;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 4'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    checkOutput("busy ready", 32'(bus.ready), 0);
    dones = 0; q_seen = '0; r_seen = '0; lat = 0;
    for (int i = 5; i <= 16; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        dones++;
        lat    = i;
        q_seen = 32'(bus.quotient);
        r_seen = 32'(bus.remainder);
      end
    end
    checkOutput("busy done_count", dones, 1);
    checkOutput("busy latency", lat, 9);
    checkOutput("busy quotient", q_seen, 14);
    checkOutput("busy remainder", r_seen, 2);

    // Start held high across done: only taken again once ready returns.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd3; bus.divisor = 4'd5;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("held latency", lat, 9);
    bus.dividend = 8'd255; bus.divisor = 4'd1;
    @(posedge clk); #1;
    checkOutput("held ready", 32'(bus.ready), 1);
    @(posedge clk); #1 bus.start = 1'b0;
    checkOutput("held accept", 32'(bus.ready), 0);
    checkOutput("held old quotient", 32'(bus.quotient), 0);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("held2 latency", lat, 9);
    checkOutput("held2 quotient", 32'(bus.quotient), 255);
    checkOutput("held2 remainder", 32'(bus.remainder), 0);

    // Reset mid-operation discards the result.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd9;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst ready", 32'(bus.ready), 1);
    checkOutput("midrst done", 32'(bus.done), 0);
    checkOutput("midrst quotient", 32'(bus.quotient), 0);
    checkOutput("midrst remainder", 32'(bus.remainder), 0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    checkOutput("midrst no_done", dones, 0);
    applyStimulus(8'd50, 4'd6, 8, 2, 9, "50/6");

    applyStimulus(8'd77, 4'd0, 255, 13, ZERO_LAT, "77/0");
`ifdef DIV_ZERO_ERR_EN
    checkOutput("77/0 div_err", 32'(bus.div_err), 1);
`endif
    applyStimulus(8'd10, 4'd3, 3, 1, 9, "10/3");
`ifdef DIV_ZERO_ERR_EN
    checkOutput("10/3 div_err", 32'(bus.div_err), 0);
`endif

    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        applyStimulus(N'(a * b), M'(b), a, 0, N + 1, $sformatf("mul %0d*%0d", a, b));
      end
    end

    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        applyStimulus(N'(a), M'(b), a / b, a % b, N + 1, $sformatf("exh %0d/%0d", a, b));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
